axi_sram_rd_slave: RTL

- AXI-lite read-only slave that sits directly downstream of the IFU/LSU read arbiter.
- Consumes its master-side AR channel and produces its R channel.
- Backing store is an on-chip word array, optionally preloaded from a hex file.
- Response latency is programmable, so arbiter ordering and back-pressure can be exercised under realistic memory timing.

---
 rtl/axi_pkg.sv | 19 +
 rtl/sram_delay_lfsr.sv | 24 ++
 rtl/axi_sram_rd_slave.sv | 126 ++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM read slave: bus-width macros and response codes.
// The optional random-delay build is selected with YSYX_23060251_SRAM_RAND_DELAY_EN in the slave.
`ifndef YSYX_23060251_AXI_ADDR_BUS
`define YSYX_23060251_AXI_ADDR_BUS 32
`endif
`ifndef YSYX_23060251_AXI_DATA_BUS
`define YSYX_23060251_AXI_DATA_BUS 32
`endif

package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

endpackage

// File: rtl/sram_delay_lfsr.sv
// Random response-delay source for the SRAM read slave (used only with YSYX_23060251_SRAM_RAND_DELAY_EN).
// A 4-bit maximal-length LFSR (x^4+x^3+1) free-runs and feeds the delay-counter load value.
module sram_delay_lfsr (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [3:0] lat_i,
   output logic [3:0] load_o
);

   logic [3:0] lfsr;

   // Seed is non-zero, so the sequence never reaches the all-zero lock-up state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         lfsr <= 4'b1001;
      end else begin
         lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      end
   end

   assign load_o = en_i ? lfsr : lat_i;

endmodule

// File: rtl/axi_sram_rd_slave.sv
// AXI-lite read-only slave backed by an on-chip word array with programmable response latency.
// Define YSYX_23060251_SRAM_RAND_DELAY_EN to replace the fixed LATENCY with an LFSR-driven delay.
// Handshake rule: a transfer happens on a rising edge where valid and ready are both 1; valid never
// depends on ready, and once r_valid is raised data/resp are held until r_ready is seen.
module axi_sram_rd_slave
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   slv_ar_valid_i,
  input  logic [`YSYX_23060251_AXI_ADDR_BUS-1:0] slv_ar_addr_i,
  output logic                                   slv_ar_ready_o,
  output logic                                   slv_r_valid_o,
  output logic [`YSYX_23060251_AXI_DATA_BUS-1:0] slv_r_data_o,
  output axi_resp_t                              slv_r_resp_o,
  input  logic                                   slv_r_ready_i,
  output logic [2:0]                             dbg_state_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_WAIT = 3'b010,
    S_RESP = 3'b100
  } state_t;

  state_t                                 state;
  logic [3:0]                             cnt;
  logic [`YSYX_23060251_AXI_ADDR_BUS-1:0] addr_q;
  logic [`YSYX_23060251_AXI_DATA_BUS-1:0] mem [DEPTH_WORDS];

  logic [3:0]                             load_val;
  logic [`YSYX_23060251_AXI_ADDR_BUS-1:0] rd_addr;
  logic [29:0]                            word_off;
  logic                                   hit;
  logic [IDX_W-1:0]                       rd_idx;
  logic [`YSYX_23060251_AXI_DATA_BUS-1:0] rd_word;
  axi_resp_t                              rd_resp;
  logic                                   ar_hs;

`ifdef YSYX_23060251_SRAM_RAND_DELAY_EN
  sram_delay_lfsr u_delay_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (1'b1),
    .lat_i  (4'(LATENCY)),
    .load_o (load_val)
  );
`else
  assign load_val = 4'(LATENCY);
`endif

  assign ar_hs       = slv_ar_valid_i & slv_ar_ready_o;
  assign dbg_state_o = state;

  // The zero-latency path reads straight from the incoming address, before it is latched.
  always_comb begin
    rd_addr  = (state == S_IDLE) ? slv_ar_addr_i : addr_q;
    word_off = 30'((rd_addr - BASE_ADDR) >> 2);
    hit      = (rd_addr >= BASE_ADDR) && ({2'b00, word_off} < 32'(DEPTH_WORDS));
    rd_idx   = word_off[IDX_W-1:0];
    rd_word  = hit ? mem[rd_idx] : '0;
    rd_resp  = hit ? OKAY : DECERR;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      addr_q         <= '0;
      slv_ar_ready_o <= 1'b0;
      slv_r_valid_o  <= 1'b0;
      slv_r_data_o   <= '0;
      slv_r_resp_o   <= OKAY;
    end else begin
      case (state)
        S_IDLE: begin
          slv_ar_ready_o <= 1'b1;
          if (ar_hs) begin
            addr_q         <= slv_ar_addr_i;
            cnt            <= load_val;
            slv_ar_ready_o <= 1'b0;
            if (load_val == 4'd0) begin
              state         <= S_RESP;
              slv_r_valid_o <= 1'b1;
              slv_r_data_o  <= rd_word;
              slv_r_resp_o  <= rd_resp;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          slv_ar_ready_o <= 1'b0;
          cnt            <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state         <= S_RESP;
            slv_r_valid_o <= 1'b1;
            slv_r_data_o  <= rd_word;
            slv_r_resp_o  <= rd_resp;
          end
        end
        S_RESP: begin
          // Data and resp are held untouched until the master accepts them.
          if (slv_r_ready_i) begin
            state          <= S_IDLE;
            slv_r_valid_o  <= 1'b0;
            slv_ar_ready_o <= 1'b1;
          end
        end
        default: begin
          state          <= S_IDLE;
          slv_ar_ready_o <= 1'b0;
          slv_r_valid_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
